des_round_key_scheduler: RTL and testbench

DES_ROUND_KEY_SCHEDULER -- requirements
Module: des_round_key_scheduler

---
 rtl/des_pkg.sv | 48 ++++
 rtl/des_pc2.sv | 14 +
 rtl/des_round_key_scheduler.sv | 121 ++++++++++++
 tb/tb_des_round_key_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-2 selection table, per-round shift
// schedule, scheduler state encoding and 28-bit rotate helpers.
// Buses are MSB-first: FIPS bit n of a W-bit bus lives at index W-n, so hex
// literals read exactly as printed in FIPS 46.
package des_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinish
  } state_e;

  // FIPS 46 PC-2: subkey bit i+1 takes CD bit Pc2Table[i] (1-based).
  localparam int unsigned Pc2Table [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount applied to reach round i+1.
  localparam logic [1:0] ShiftSchedule [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Left rotate: FIPS bit n takes bit n+amt, wrapping at 28.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
    logic [27:0] r;
    case (amt)
      2'd1:    r = {x[26:0], x[27]};
      2'd2:    r = {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    logic [27:0] r;
    case (amt)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: 56-bit C||D in, 48-bit round key out. Pure wiring.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] subkey_o
);

  // Each output bit is a fixed pick from C||D; FIPS bit n sits at index W-n.
  for (genvar i = 0; i < 48; i++) begin : gen_bit
    assign subkey_o[47 - i] = cd_i[56 - Pc2Table[i]];
  end

endmodule

// File: rtl/des_round_key_scheduler.sv
// DES round-key scheduler: latches C0/D0 on START and walks C,D through the
// 16 rotations, emitting one PC-2 subkey per unstalled cycle. Decrypt starts
// from C16=C0 and rotates right, so K16 comes out first.
module des_round_key_scheduler
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic        DECRYPT,
  input  logic        STALL,
  input  logic [27:0] RIGHT_CIRCULAR_SHIFT1,
  input  logic [27:0] LEFT_CIRCULAR_SHIFT1,
  output logic [47:0] SUBKEY,
  output logic        SUBKEY_VALID,
  output logic [3:0]  ROUND_NUMBER,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [3:0] LastRound = 4'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        decrypt_q, decrypt_d;
  logic [1:0]  step_amt;
  logic        last_round;
  logic [47:0] pc2_key;

  assign last_round = (round_q == LastRound);

  // State register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; START is only honoured in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (START) state_d = StRound;
      StRound:  if (!STALL && last_round) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Rotation amount for the step leaving the current round. Leaving round 16
  // decrypt still owes one position so both modes finish a full 28.
  always_comb begin
    if (last_round) begin
      step_amt = decrypt_q ? 2'd1 : 2'd0;
    end else begin
      step_amt = ShiftSchedule[round_q + 4'd1];
    end
  end

  // Datapath next-state: load on START, rotate/advance on each unstalled round.
  always_comb begin
    c_d       = c_q;
    d_d       = d_q;
    round_d   = round_q;
    decrypt_d = decrypt_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          decrypt_d = DECRYPT;
          round_d   = 4'd0;
          c_d       = DECRYPT ? RIGHT_CIRCULAR_SHIFT1 : rotl28(RIGHT_CIRCULAR_SHIFT1, 2'd1);
          d_d       = DECRYPT ? LEFT_CIRCULAR_SHIFT1 : rotl28(LEFT_CIRCULAR_SHIFT1, 2'd1);
        end
      end
      StRound: begin
        if (!STALL) begin
          c_d = decrypt_q ? rotr28(c_q, step_amt) : rotl28(c_q, step_amt);
          d_d = decrypt_q ? rotr28(d_q, step_amt) : rotl28(d_q, step_amt);
          if (!last_round) round_d = round_q + 4'd1;
        end
      end
      StFinish: round_d = 4'd0;
      default:  round_d = 4'd0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      c_q       <= '0;
      d_q       <= '0;
      round_q   <= '0;
      decrypt_q <= 1'b0;
    end else begin
      c_q       <= c_d;
      d_q       <= d_d;
      round_q   <= round_d;
      decrypt_q <= decrypt_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (pc2_key)
  );

  // Outputs decoded from state; the key is masked outside ROUND.
  always_comb begin
    BUSY         = (state_q == StRound);
    SUBKEY_VALID = (state_q == StRound);
    DONE         = (state_q == StFinish);
    ROUND_NUMBER = round_q;
    SUBKEY       = (state_q == StRound) ? pc2_key : 48'h0;
  end

endmodule

// File: tb/tb_des_round_key_scheduler.sv
// Bench for des_round_key_scheduler. Expected subkeys come from a FIPS-style
// model: K_i = PC2(rotl(C0,s_i), rotl(D0,s_i)) with s_i the cumulative shift.
module tb_des_round_key_scheduler;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        START;
  logic        DECRYPT;
  logic        STALL;
  logic [27:0] RIGHT_CIRCULAR_SHIFT1;
  logic [27:0] LEFT_CIRCULAR_SHIFT1;
  logic [47:0] SUBKEY;
  logic        SUBKEY_VALID;
  logic [3:0]  ROUND_NUMBER;
  logic        BUSY;
  logic        DONE;

  int n_cmp = 0;
  int n_err = 0;

  localparam int Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int Shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [27:0] KeyC0 = 28'hF0CCAAF;
  localparam logic [27:0] KeyD0 = 28'h556678F;
  localparam logic [47:0] KeyK1 = 48'h1B02EFFC7072;
  localparam logic [47:0] KeyK16 = 48'hCB3D8B0E17F5;

  des_round_key_scheduler #(.ROUNDS(16)) dut (
    .CLOCK                 (CLOCK),
    .RESET                 (RESET),
    .START                 (START),
    .DECRYPT               (DECRYPT),
    .STALL                 (STALL),
    .RIGHT_CIRCULAR_SHIFT1 (RIGHT_CIRCULAR_SHIFT1),
    .LEFT_CIRCULAR_SHIFT1  (LEFT_CIRCULAR_SHIFT1),
    .SUBKEY                (SUBKEY),
    .SUBKEY_VALID          (SUBKEY_VALID),
    .ROUND_NUMBER          (ROUND_NUMBER),
    .BUSY                  (BUSY),
    .DONE                  (DONE)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [27:0] m_rotl(input logic [27:0] x, input int n);
    logic [55:0] dd;
    dd = {x, x};
    return dd[55 - n -: 28];
  endfunction

  function automatic logic [47:0] m_pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] k;
    cd = {c, d};
    for (int i = 1; i <= 48; i++) k[48 - i] = cd[56 - Pc2Tab[i - 1]];
    return k;
  endfunction

  // keys[i] holds K(i+1), in encrypt order.
  task automatic m_keys(input logic [27:0] c0, input logic [27:0] d0,
                        output logic [47:0] keys [16]);
    int tot;
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      tot += Shifts[i];
      keys[i] = m_pc2(m_rotl(c0, tot % 28), m_rotl(d0, tot % 28));
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // One full sequence. stall_at/poke_at < 0 disable the stall / mid-run START.
  // first_key/last_key report the keys seen at ROUND_NUMBER 0 and 15.
  task automatic run_seq(input logic [27:0] c0, input logic [27:0] d0, input logic dec,
                         input int stall_at, input int stall_len, input int poke_at,
                         output int valid_cycles, output logic [47:0] first_key,
                         output logic [47:0] last_key);
    logic [47:0] keys [16];
    logic [47:0] exp_k;
    m_keys(c0, d0, keys);
    valid_cycles = 0;
    RIGHT_CIRCULAR_SHIFT1 = c0;
    LEFT_CIRCULAR_SHIFT1  = d0;
    DECRYPT = dec;
    START   = 1'b1;
    tick();
    START   = 1'b0;
    DECRYPT = 1'($urandom);
    for (int r = 0; r < 16; r++) begin
      exp_k = dec ? keys[15 - r] : keys[r];
      check("round_number", 64'(ROUND_NUMBER), 64'(r));
      check("subkey", 64'(SUBKEY), 64'(exp_k));
      check("subkey_valid", 64'(SUBKEY_VALID), 64'd1);
      check("busy", 64'(BUSY), 64'd1);
      check("done_early", 64'(DONE), 64'd0);
      if (r == 0) first_key = SUBKEY;
      if (r == 15) last_key = SUBKEY;
      valid_cycles += int'(SUBKEY_VALID);
      // Inputs after START must have no effect.
      RIGHT_CIRCULAR_SHIFT1 = 28'($urandom);
      LEFT_CIRCULAR_SHIFT1  = 28'($urandom);
      if (r == stall_at) begin
        STALL = 1'b1;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_round", 64'(ROUND_NUMBER), 64'(r));
          check("stall_subkey", 64'(SUBKEY), 64'(exp_k));
          check("stall_done", 64'(DONE), 64'd0);
          valid_cycles += int'(SUBKEY_VALID);
        end
        STALL = 1'b0;
      end
      if (r == poke_at) START = 1'b1;
      tick();
      START = 1'b0;
    end
    check("done_pulse", 64'(DONE), 64'd1);
    check("finish_valid", 64'(SUBKEY_VALID), 64'd0);
    check("finish_busy", 64'(BUSY), 64'd0);
    // START during FINISH must be ignored.
    START = 1'b1;
    tick();
    START = 1'b0;
    check("done_one_cycle", 64'(DONE), 64'd0);
    check("idle_busy", 64'(BUSY), 64'd0);
    check("idle_subkey", 64'(SUBKEY), 64'd0);
    tick();
    check("idle_stays", 64'(BUSY), 64'd0);
  endtask

  int          vc;
  logic [47:0] fk, lk;
  logic [27:0] rc, rd;

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    DECRYPT = 1'b0;
    STALL = 1'b0;
    RIGHT_CIRCULAR_SHIFT1 = '0;
    LEFT_CIRCULAR_SHIFT1  = '0;
    tick();
    tick();
    check("rst_subkey", 64'(SUBKEY), 64'd0);
    check("rst_valid", 64'(SUBKEY_VALID), 64'd0);
    check("rst_round", 64'(ROUND_NUMBER), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    RESET = 1'b0;
    tick();

    // Known-answer encrypt and decrypt.
    run_seq(KeyC0, KeyD0, 1'b0, -1, 0, -1, vc, fk, lk);
    check("enc_k1", 64'(fk), 64'(KeyK1));
    check("enc_k16", 64'(lk), 64'(KeyK16));
    run_seq(KeyC0, KeyD0, 1'b1, -1, 0, -1, vc, fk, lk);
    check("dec_first", 64'(fk), 64'(KeyK16));
    check("dec_last", 64'(lk), 64'(KeyK1));

    // Back-pressure at round 4, then on the last round.
    run_seq(KeyC0, KeyD0, 1'b0, 4, 3, -1, vc, fk, lk);
    check("stall_valid_cycles", 64'(vc), 64'd19);
    run_seq(KeyC0, KeyD0, 1'b1, 15, 2, -1, vc, fk, lk);
    check("stall_last_cycles", 64'(vc), 64'd18);

    // START mid-sequence is ignored.
    run_seq(KeyC0, KeyD0, 1'b0, -1, 0, 7, vc, fk, lk);

    // Asynchronous reset at round 9 aborts without DONE.
    RIGHT_CIRCULAR_SHIFT1 = KeyC0;
    LEFT_CIRCULAR_SHIFT1  = KeyD0;
    DECRYPT = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (9) tick();
    check("pre_reset_round", 64'(ROUND_NUMBER), 64'd9);
    #2 RESET = 1'b1;
    #1;
    check("async_subkey", 64'(SUBKEY), 64'd0);
    check("async_valid", 64'(SUBKEY_VALID), 64'd0);
    check("async_round", 64'(ROUND_NUMBER), 64'd0);
    check("async_busy", 64'(BUSY), 64'd0);
    check("async_done", 64'(DONE), 64'd0);
    tick();
    RESET = 1'b0;
    tick();
    check("post_reset_done", 64'(DONE), 64'd0);
    check("post_reset_busy", 64'(BUSY), 64'd0);
    run_seq(KeyC0, KeyD0, 1'b0, -1, 0, -1, vc, fk, lk);
    check("restart_k1", 64'(fk), 64'(KeyK1));

    // RESET wins over a coincident START.
    RESET = 1'b1;
    START = 1'b1;
    tick();
    RESET = 1'b0;
    START = 1'b0;
    check("rst_start_busy", 64'(BUSY), 64'd0);
    tick();
    check("rst_start_idle", 64'(BUSY), 64'd0);

    // All-zero and all-one keys.
    run_seq(28'h0, 28'h0, 1'b0, -1, 0, -1, vc, fk, lk);
    run_seq(28'hFFFFFFF, 28'hFFFFFFF, 1'b1, -1, 0, -1, vc, fk, lk);
    check("ones_key", 64'(fk), 64'(48'hFFFFFFFFFFFF));

    // Random keys, modes and stall placement.
    for (int t = 0; t < 6; t++) begin
      rc = 28'($urandom);
      rd = 28'($urandom);
      run_seq(rc, rd, 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(1, 3)),
              int'($urandom_range(0, 15)), vc, fk, lk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
